id_inst_buffer: RTL and testbench

ID_INST_BUFFER -- requirements
Module: id_inst_buffer

---
 rtl/id_inst_buffer.sv | 94 +++++++++
 tb/tb_id_inst_buffer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/id_inst_buffer.sv
// Fetch-to-decode instruction buffer: circular FIFO of {sideband, instruction} entries.
// Optional same-cycle empty-buffer bypass is enabled by defining ID_INST_BUFFER_BYPASS_EN.
module id_inst_buffer #(
  parameter int unsigned FS_TO_DS_BUS_WD = 34,
  parameter int unsigned INST_WD         = 32,
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned CNT_WD          = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       br_flush,
  input  logic                       fs_valid,
  input  logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
  input  logic [INST_WD-1:0]         inst_sram_rdata,
  output logic                       fs_ready,
  input  logic                       ds_allowin,
  output logic                       ds_valid,
  output logic [FS_TO_DS_BUS_WD-1:0] ds_bus,
  output logic [INST_WD-1:0]         ds_inst,
  output logic [CNT_WD-1:0]          count
);

  localparam int unsigned PTR_WD = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PTR_WD-1:0]          wr_ptr;
  logic [PTR_WD-1:0]          rd_ptr;
  logic [CNT_WD-1:0]          count_q;
  logic [FS_TO_DS_BUS_WD-1:0] bus_mem  [DEPTH];
  logic [INST_WD-1:0]         inst_mem [DEPTH];

  logic kill_c;
  logic stored_c;
  logic bypass_c;
  logic push_c;
  logic pop_c;

  assign count = count_q;

  // Handshake decode; with bypass off every output depends only on registers.
  always_comb begin
    kill_c   = flush | br_flush;
    stored_c = (count_q != '0);
    fs_ready = (count_q < CNT_WD'(DEPTH));
`ifdef ID_INST_BUFFER_BYPASS_EN
    bypass_c = !stored_c & fs_valid & !kill_c;
`else
    bypass_c = 1'b0;
`endif
    // A bypassed entry consumed by decode this cycle is never stored.
    push_c   = fs_valid & fs_ready & !kill_c & !(bypass_c & ds_allowin);
    pop_c    = stored_c & ds_allowin & !kill_c;
    ds_valid = stored_c | bypass_c;
    ds_bus   = '0;
    ds_inst  = '0;
    if (stored_c) begin
      ds_bus  = bus_mem[rd_ptr];
      ds_inst = inst_mem[rd_ptr];
    end else if (bypass_c) begin
      ds_bus  = fs_to_ds_bus;
      ds_inst = inst_sram_rdata;
    end
  end

  // Pointers and occupancy; a flush wins over any same-cycle push/pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (kill_c) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PTR_WD'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PTR_WD'(1);
      case ({push_c, pop_c})
        2'b10:   count_q <= count_q + CNT_WD'(1);
        2'b01:   count_q <= count_q - CNT_WD'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage is written once on push and needs no reset.
  always_ff @(posedge clk) begin
    if (push_c) begin
      bus_mem[wr_ptr]  <= fs_to_ds_bus;
      inst_mem[wr_ptr] <= inst_sram_rdata;
    end
  end

endmodule

// File: tb/tb_id_inst_buffer.sv
// Directed self-checking bench for id_inst_buffer (DEPTH=4).
module tb_id_inst_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        br_flush;
  logic        fs_valid;
  logic [33:0] fs_to_ds_bus;
  logic [31:0] inst_sram_rdata;
  logic        fs_ready;
  logic        ds_allowin;
  logic        ds_valid;
  logic [33:0] ds_bus;
  logic [31:0] ds_inst;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  id_inst_buffer dut (
    .clk            (clk),
    .reset          (reset),
    .flush          (flush),
    .br_flush       (br_flush),
    .fs_valid       (fs_valid),
    .fs_to_ds_bus   (fs_to_ds_bus),
    .inst_sram_rdata(inst_sram_rdata),
    .fs_ready       (fs_ready),
    .ds_allowin     (ds_allowin),
    .ds_valid       (ds_valid),
    .ds_bus         (ds_bus),
    .ds_inst        (ds_inst),
    .count          (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [33:0] mk_bus(input logic [31:0] pc);
    return {1'b1, 1'b0, pc};
  endfunction

  function automatic logic [31:0] mk_inst(input logic [31:0] pc);
    return ~pc;
  endfunction

  task automatic offer(input logic [31:0] pc);
    fs_valid        = 1'b1;
    fs_to_ds_bus    = mk_bus(pc);
    inst_sram_rdata = mk_inst(pc);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  initial begin
    logic [31:0] pc;
    reset = 1'b1; flush = 1'b0; br_flush = 1'b0; fs_valid = 1'b0;
    fs_to_ds_bus = '0; inst_sram_rdata = '0; ds_allowin = 1'b0;
    #3;
    check("rst_count", 64'(count), 64'd0);
    check("rst_fs_ready", 64'(fs_ready), 64'd1);
    check("rst_ds_valid", 64'(ds_valid), 64'd0);
    check("rst_ds_bus", 64'(ds_bus), 64'd0);
    check("rst_ds_inst", 64'(ds_inst), 64'd0);
    tick; tick;
    reset = 1'b0;

    // Fill to full with decode stalled.
    for (int i = 0; i < 4; i++) begin
      offer(32'h1c00_0000 + 32'(4 * i));
      tick;
      check($sformatf("fill_count%0d", i), 64'(count), 64'(i + 1));
      if (i == 0) begin
        check("lat1_valid", 64'(ds_valid), 64'd1);
        check("lat1_bus", 64'(ds_bus), 64'(mk_bus(32'h1c00_0000)));
      end
    end
    check("full_fs_ready", 64'(fs_ready), 64'd0);
    offer(32'h1c00_0010);
    tick;
    check("full_reject_count", 64'(count), 64'd4);

    // Pop from full with fs_valid held: no push that cycle.
    ds_allowin = 1'b1;
    settle;
    check("full_pop_bus", 64'(ds_bus), 64'(mk_bus(32'h1c00_0000)));
    check("full_pop_inst", 64'(ds_inst), 64'(mk_inst(32'h1c00_0000)));
    tick;
    check("full_pop_count", 64'(count), 64'd3);
    check("full_pop_ready", 64'(fs_ready), 64'd1);
    ds_allowin = 1'b0;
    tick;
    check("refill_count", 64'(count), 64'd4);

    // Drain to two entries: 0x..0c and 0x..10 remain.
    fs_valid = 1'b0; ds_allowin = 1'b1;
    tick; tick;
    check("drain_count", 64'(count), 64'd2);

    // Steady push+pop for 10 cycles, pointers wrap.
    for (int k = 0; k < 10; k++) begin
      offer(32'h1c00_0014 + 32'(4 * k));
      settle;
      check($sformatf("stream_bus%0d", k), 64'(ds_bus), 64'(mk_bus(32'h1c00_000c + 32'(4 * k))));
      tick;
      check($sformatf("stream_count%0d", k), 64'(count), 64'd2);
    end
    check("stream_tail_inst", 64'(ds_inst), 64'(mk_inst(32'h1c00_0034)));

    // Grow to three, then branch flush with a fetch offer.
    ds_allowin = 1'b0;
    offer(32'h1c00_003c);
    tick;
    check("pre_flush_count", 64'(count), 64'd3);
    offer(32'h1c00_0040);
    br_flush = 1'b1;
    tick;
    br_flush = 1'b0; fs_valid = 1'b0;
    check("brf_count", 64'(count), 64'd0);
    check("brf_valid", 64'(ds_valid), 64'd0);
    check("brf_bus", 64'(ds_bus), 64'd0);
    check("brf_inst", 64'(ds_inst), 64'd0);
    tick;
    check("brf_no_ghost", 64'(ds_valid), 64'd0);
    offer(32'h1c00_0050);
    tick;
    check("post_brf_bus", 64'(ds_bus), 64'(mk_bus(32'h1c00_0050)));
    offer(32'h1c00_0054);
    tick;
    check("pre_dflush_count", 64'(count), 64'd2);
    flush = 1'b1; br_flush = 1'b1;
    tick;
    flush = 1'b0; br_flush = 1'b0; fs_valid = 1'b0;
    check("dflush_count", 64'(count), 64'd0);
    check("dflush_valid", 64'(ds_valid), 64'd0);

    // Asynchronous reset between edges with two entries.
    offer(32'h1c00_0058); tick;
    offer(32'h1c00_005c); tick;
    fs_valid = 1'b0;
    check("pre_rst_count", 64'(count), 64'd2);
    #2;
    reset = 1'b1;
    #1;
    check("arst_count", 64'(count), 64'd0);
    check("arst_valid", 64'(ds_valid), 64'd0);
    check("arst_bus", 64'(ds_bus), 64'd0);
    check("arst_ready", 64'(fs_ready), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    offer(32'h1c00_0060);
    tick;
    fs_valid = 1'b0;
    check("post_rst_count", 64'(count), 64'd1);
    check("post_rst_bus", 64'(ds_bus), 64'(mk_bus(32'h1c00_0060)));
    ds_allowin = 1'b1;
    tick;
    check("post_rst_empty", 64'(count), 64'd0);

    // Empty buffer offer with decode ready.
    pc = 32'h1c00_0070;
    fs_valid = 1'b1; fs_to_ds_bus = mk_bus(pc); inst_sram_rdata = 32'h0280_0421;
    ds_allowin = 1'b1;
    settle;
`ifdef ID_INST_BUFFER_BYPASS_EN
    check("byp_valid", 64'(ds_valid), 64'd1);
    check("byp_inst", 64'(ds_inst), 64'h0280_0421);
    tick;
    fs_valid = 1'b0;
    check("byp_count", 64'(count), 64'd0);
`else
    check("nobyp_valid", 64'(ds_valid), 64'd0);
    check("nobyp_inst0", 64'(ds_inst), 64'd0);
    tick;
    fs_valid = 1'b0;
    settle;
    check("nobyp_head_valid", 64'(ds_valid), 64'd1);
    check("nobyp_head_inst", 64'(ds_inst), 64'h0280_0421);
    check("nobyp_count", 64'(count), 64'd1);
`endif
    tick;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
